// File: rtl/fpu_defs.sv
// Shared constants and types for the FPU conversion path.
// Includes the scheduler's in-flight tag type.
package fpu_defs;

  localparam int C_OP              = 32;
  localparam int C_ITOF_SCHED_NREQ = 4;
  localparam int C_ITOF_UNIT_LAT   = 2;
  localparam int C_ITOF_IDX_W      = $clog2(C_ITOF_SCHED_NREQ);

  typedef struct packed {
    logic                    valid;
    logic [C_ITOF_IDX_W-1:0] idx;
  } itof_tag_t;

endpackage

// File: rtl/fpu_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// prio, wrapping from N-1 to 0. The pointer register is kept by the parent.
module fpu_rr_arb #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prio,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(prio) + k) % N;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_itof_sched.sv
// Shares one fixed-latency itof unit among NUM_REQ requesters; a tag shift
// register follows each operation so its result returns to the right owner.
module fpu_itof_sched
  import fpu_defs::*;
#(
  parameter int NUM_REQ  = C_ITOF_SCHED_NREQ,
  parameter int UNIT_LAT = C_ITOF_UNIT_LAT
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RBI,
  input  logic                           Enable_SI,
  input  logic                           Flush_SI,
  input  logic [NUM_REQ-1:0]             Req_SI,
  input  logic [NUM_REQ-1:0][C_OP-1:0]   Operand_DI,
  output logic [NUM_REQ-1:0]             Gnt_SO,
  output logic                           Conv_valid_SO,
  output logic [C_OP-1:0]                Conv_operand_DO,
  input  logic [C_OP-1:0]                Conv_result_DI,
  output logic [NUM_REQ-1:0]             Result_valid_SO,
  output logic [C_OP-1:0]                Result_DO
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = C_ITOF_IDX_W;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [IW-1:0] prio_q;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] prio_next;
  logic          gnt_any;
  logic          arb_en;
  itof_tag_t     tag_q [UNIT_LAT+1];

  // Reset gates the grant combinationally so nothing is handed out while held.
  assign arb_en    = Enable_SI & ~Flush_SI & Rst_RBI;
  assign gnt_any   = |Gnt_SO;
  assign prio_next = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);

  fpu_rr_arb #(.N(NUM_REQ)) u_arb (
    .req  (Req_SI),
    .prio (prio_q),
    .en   (arb_en),
    .gnt  (Gnt_SO),
    .idx  (gnt_idx)
  );

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      prio_q          <= '0;
      Conv_valid_SO   <= 1'b0;
      Conv_operand_DO <= '0;
      Result_valid_SO <= '0;
      Result_DO       <= '0;
      for (int s = 0; s <= UNIT_LAT; s++) tag_q[s] <= '0;
    end else if (Flush_SI) begin
      Conv_valid_SO   <= 1'b0;
      Result_valid_SO <= '0;
      for (int s = 0; s <= UNIT_LAT; s++) tag_q[s].valid <= 1'b0;
    end else begin
      Conv_valid_SO <= gnt_any;
      if (gnt_any) begin
        Conv_operand_DO <= Operand_DI[gnt_idx];
        prio_q          <= prio_next;
      end
      tag_q[0].valid <= gnt_any;
      tag_q[0].idx   <= TW'(gnt_idx);
      for (int s = 1; s <= UNIT_LAT; s++) tag_q[s] <= tag_q[s-1];
      // The last stage lines up with the unit's result for that operation.
      if (tag_q[UNIT_LAT].valid) begin
        Result_DO       <= Conv_result_DI;
        Result_valid_SO <= ONE << tag_q[UNIT_LAT].idx;
      end else begin
        Result_valid_SO <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_itof_sched.sv
// Bench for fpu_itof_sched: random and directed requests, a fixed-latency
// itof unit model, and a scoreboard of expected owner/result/arrival cycle.
module tb_fpu_itof_sched;
  import fpu_defs::*;

  localparam int N = 4;
  localparam int L = 2;

  typedef struct packed {
    logic [N-1:0] oh;
    logic [31:0]  res;
    logic [31:0]  cyc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic                   flush = 1'b0;
  logic [N-1:0]           req = '0;
  logic [N-1:0][C_OP-1:0] ops = '0;
  logic [N-1:0]           gnt;
  logic                   conv_valid;
  logic [C_OP-1:0]        conv_op;
  logic [C_OP-1:0]        conv_res;
  logic [N-1:0]           res_valid;
  logic [C_OP-1:0]        result;

  exp_t         exp_q[$];
  exp_t         e;
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           mprio = 0;
  int           gi;
  logic         prev_any = 1'b0;
  logic [31:0]  prev_op = '0;
  logic [N-1:0] seen_gnt = '0;
  logic [N-1:0] eg;
  logic [C_OP-1:0] upipe [L];

  always #5 clk = ~clk;

  // Reference int32 -> float32 conversion, round to nearest even.
  function automatic logic [31:0] itof(input logic [31:0] v);
    logic [31:0] mag, m, rem, half;
    int ex, sh;
    if (v == 32'd0) return 32'd0;
    mag = v[31] ? (~v + 32'd1) : v;
    ex = 31;
    while (!mag[ex]) ex--;
    if (ex <= 23) begin
      m = mag << (23 - ex);
    end else begin
      sh   = ex - 23;
      m    = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m  = m >> 1;
        ex = ex + 1;
      end
    end
    return {v[31], 8'(ex + 127), m[22:0]};
  endfunction

  // Shared unit model: result appears L cycles after the operand is presented.
  always @(posedge clk) begin
    upipe[0] <= conv_op;
    for (int i = 1; i < L; i++) upipe[i] <= upipe[i-1];
  end
  assign conv_res = itof(upipe[L-1]);

  fpu_itof_sched #(.NUM_REQ(N), .UNIT_LAT(L)) dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .Enable_SI       (en),
    .Flush_SI        (flush),
    .Req_SI          (req),
    .Operand_DI      (ops),
    .Gnt_SO          (gnt),
    .Conv_valid_SO   (conv_valid),
    .Conv_operand_DO (conv_op),
    .Conv_result_DI  (conv_res),
    .Result_valid_SO (res_valid),
    .Result_DO       (result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    seen_gnt = gnt;
    if (!rst_n) begin
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_conv_valid", 64'(conv_valid), 64'd0);
      check("rst_conv_operand", 64'(conv_op), 64'd0);
      check("rst_result_valid", 64'(res_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      exp_q.delete();
      mprio    = 0;
      prev_any = 1'b0;
    end else begin
      if (res_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(res_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_owner", 64'(res_valid), 64'(e.oh));
          check("result_value", 64'(result), 64'(e.res));
          check("result_latency", 64'(cyc), 64'(e.cyc + L + 2));
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0].cyc) + L + 2 == cyc) begin
        check("missing_result", 64'(res_valid), 64'(exp_q[0].oh));
        void'(exp_q.pop_front());
      end
      check("conv_valid", 64'(conv_valid), 64'(prev_any));
      if (prev_any) check("conv_operand", 64'(conv_op), 64'(prev_op));
      eg = '0;
      gi = -1;
      if (en && !flush)
        for (int k = 0; k < N; k++)
          if (gi < 0 && req[(mprio + k) % N]) gi = (mprio + k) % N;
      if (gi >= 0) eg[gi] = 1'b1;
      check("grant", 64'(gnt), 64'(eg));
      if (flush) exp_q.delete();
      prev_any = (gi >= 0);
      if (gi >= 0) begin
        prev_op = ops[gi];
        e.oh  = eg;
        e.res = itof(ops[gi]);
        e.cyc = 32'(cyc);
        exp_q.push_back(e);
        mprio = (gi + 1) % N;
      end
    end
  end

  // Requests are held until granted; granted bits drop after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~seen_gnt;
  endtask

  task automatic add_req(input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[i] && !req[i]) begin
        req[i] = 1'b1;
        ops[i] = $urandom;
      end
  endtask

  task automatic drain();
    req = '0;
    repeat (L + 4) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;

    // Single request, known conversion
    ops[2] = 32'hFFFF_FFFF;
    req    = 4'b0100;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid != '0) break;
    end
    check("single_valid", 64'(res_valid), 64'h4);
    check("single_result", 64'(result), 64'hBF80_0000);
    drain();

    // All four requesting continuously from reset
    do_reset();
    add_req('1);
    repeat (16) begin
      step();
      add_req('1);
    end
    drain();

    // Wrap-around: pointer at 1, requests 0 and 3
    do_reset();
    req = 4'b0001;
    ops[0] = $urandom;
    step();
    add_req(4'b1001);
    step();
    step();
    drain();

    // Flush after three back-to-back grants
    add_req('1);
    step();
    add_req('1);
    step();
    add_req('1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    drain();

    // Enable low with everyone requesting; in-flight work still returns
    add_req('1);
    step();
    step();
    en = 1'b0;
    add_req('1);
    repeat (5) step();
    en = 1'b1;
    step();
    step();
    drain();

    // Reset mid-stream with two operations in flight
    add_req('1);
    step();
    step();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req = '0;
    add_req(4'b1001);
    step();
    step();
    drain();

    // Random traffic
    repeat (400) begin
      step();
      add_req(N'($urandom_range(0, 15)));
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
    end
    flush = 1'b0;
    en    = 1'b1;
    drain();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_itof_sched.md
# fpu_itof_sched

Round-robin scheduler that shares one integer-to-float conversion unit (itof front end plus normalizer/rounder, fixed latency) among NUM_REQ requesters. It arbitrates requests and registers the granted operand into the unit. It tracks the requester tag of every in-flight operation in a shift register and routes each returning result to its owner with a one-hot valid. It sits between the core-side issue ports and the single shared conversion datapath.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- UNIT_LAT, 2: cycles from Conv_valid_SO to matching Conv_result_DI, ≥1.
- Clk_CI  in  1  clock, rising edge.
- Rst_RBI  in  1  reset; asynchronous, active-low.
- Enable_SI  in  1  when low, no new grants; in-flight operations complete.
- Flush_SI  in  1  drop all in-flight operations.
- Req_SI  in  NUM_REQ  per-requester request; held until granted.
- Operand_DI  in  NUM_REQ×C_OP  per-requester signed integer operand.
- Gnt_SO  out  NUM_REQ  one-hot grant, combinational, same cycle as request.
- Conv_valid_SO  out  1  operand valid to shared unit, registered.
- Conv_operand_DO  out  C_OP  operand to shared unit, registered.
- Conv_result_DI  in  C_OP  float result from shared unit.
- Result_valid_SO  out  NUM_REQ  one-hot result valid, registered.
- Result_DO  out  C_OP  result, registered, shared by all requesters.

## Operation
- Grant is issued when Enable_SI=1, Flush_SI=0 and any Req_SI bit is set. Exactly one Gnt_SO bit is set: the first requesting index at or after Prio_Q, searching upward and wrapping at NUM_REQ-1 to 0.
- A grant to index i makes Prio_Q = (i+1) mod NUM_REQ at the next edge. With no grant, Prio_Q holds. Reset value of Prio_Q is 0.
- On a grant, Conv_operand_DO <= Operand_DI[i] and Conv_valid_SO <= 1; otherwise Conv_valid_SO <= 0 and Conv_operand_DO holds.
- Tag pipeline has UNIT_LAT+1 stages. Each stage holds {valid, index}. Stage 0 is loaded together with Conv_valid_SO; the pipeline shifts every cycle and never stalls. The last stage is aligned with Conv_result_DI.
- When the last stage is valid, Result_DO <= Conv_result_DI and Result_valid_SO <= onehot(index) at the next edge; otherwise Result_valid_SO <= 0 and Result_DO holds.
- Flush_SI=1: Gnt_SO=0 in that cycle. All tag-stage valids, Conv_valid_SO and Result_valid_SO are 0 after the edge. Prio_Q holds. Unit results arriving later are discarded.
- Flush takes precedence over request and Enable_SI.
- A requester may have several operations in flight; results return in issue order.
- No backpressure on results: requesters must accept Result_valid_SO in the cycle it is asserted.

## Timing
- Grant in cycle t → Conv_valid_SO in t+1 → Conv_result_DI sampled in t+1+UNIT_LAT → Result_valid_SO in t+2+UNIT_LAT. Total latency is UNIT_LAT+2.
- Throughput: one grant per cycle, back-to-back.
- Reset values: Conv_valid_SO=0, Result_valid_SO=0, Conv_operand_DO=0, Result_DO=0, all tag valids=0, Prio_Q=0.
- Gnt_SO is combinational and also 0 while Rst_RBI is low.
- Reset mid-operation drops all in-flight results. No Result_valid_SO is asserted after reset release for operations issued before reset.
- Enable_SI deassert: requests already granted complete normally; pending requests wait.

## Structure
- In fpu_defs: C_OP (existing), C_ITOF_SCHED_NREQ, C_ITOF_UNIT_LAT, and a struct tag type {logic valid; logic [$clog2(NUM_REQ)-1:0] idx}.
- Sub-module fpu_rr_arb: combinational round-robin arbiter. Inputs are the request vector, the priority pointer and an enable; outputs are the one-hot grant and the granted index. The pointer register lives in fpu_itof_sched.

## Test plan
- Single request: Req_SI=4'b0100, Operand_DI[2]=32'hFFFF_FFFF, unit model returns 32'hBF80_0000 → Gnt_SO=0100 in cycle 0, Conv_valid_SO in cycle 1, Result_valid_SO=0100 with Result_DO=BF80_0000 in cycle UNIT_LAT+2.
- All four requesting continuously from reset → grant order 0,1,2,3,0,…, one per cycle. Results return in the same order with matching one-hot valids.
- Req_SI=1001 with Prio_Q=1 → grant 3, then grant 0 next cycle; wrap-around correct.
- Flush_SI pulsed one cycle after 3 back-to-back grants → no Result_valid_SO for any of them. A grant issued the cycle after the flush returns normally.
- Enable_SI=0 with Req_SI=1111 for 5 cycles → Gnt_SO=0 throughout, in-flight results still delivered. On re-enable, arbitration resumes from the unchanged Prio_Q.
- Assert Rst_RBI low mid-stream with 2 operations in flight → all outputs 0 immediately, no stale Result_valid_SO after release, Prio_Q=0.
